// File: rtl/seq_detect_ctrl.sv
// Programmable 4-bit Mealy serial pattern detector with a start/busy/done
// job handshake, frame-length sequencing and a saturating match counter.
module seq_detect_ctrl #(
  parameter int PW = 4,
  parameter int LW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [PW-1:0] pattern,
  input  logic [LW-1:0] len,
  input  logic          overlap,
  input  logic          x,
  input  logic          x_valid,
  output logic          busy,
  output logic          done,
  output logic          match,
  output logic [CW-1:0] count
);

  localparam int FW = $clog2(PW);
  localparam logic [FW-1:0] FILL_FULL = FW'(PW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [PW-1:0] pat_q;
  logic [LW-1:0] len_q;
  logic          ovl_q;
  logic [PW-2:0] hist;
  logic [FW-1:0] fill;
  logic [LW-1:0] bit_cnt;
  logic          consume;
  logic          last_bit;
  logic          accept;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    consume    = 1'b0;
    match      = 1'b0;
    last_bit   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_next = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        consume  = x_valid;
        match    = x_valid && (fill == FILL_FULL) && ({hist, x} == pat_q);
        last_bit = (bit_cnt == len_q - 1'b1);
        if (consume && last_bit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // fill counts bits eligible for the current window; a non-overlapping
  // match empties it so the next window needs PW fresh bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist    <= '0;
      fill    <= '0;
      bit_cnt <= '0;
      count   <= '0;
    end else if (accept) begin
      pat_q   <= pattern;
      len_q   <= len;
      ovl_q   <= overlap;
      hist    <= '0;
      fill    <= '0;
      bit_cnt <= '0;
      count   <= '0;
    end else if (consume) begin
      hist    <= {hist[PW-3:0], x};
      bit_cnt <= bit_cnt + 1'b1;
      if (match) begin
        if (count != '1) count <= count + 1'b1;
        if (!ovl_q) fill <= '0;
      end else if (fill != FILL_FULL) begin
        fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: queue-based reference model checked every cycle,
// plus directed jobs with hand-computed match positions and totals.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pattern = '0;
  logic [7:0] len = '0;
  logic       overlap = 1'b0;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       busy, done, match;
  logic [7:0] count;
  logic       busy2, done2, match2;
  logic [1:0] count2;

  seq_detect_ctrl #(.PW(4), .LW(8), .CW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .overlap(overlap), .x(x), .x_valid(x_valid),
    .busy(busy), .done(done), .match(match), .count(count)
  );

  seq_detect_ctrl #(.PW(4), .LW(8), .CW(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .overlap(overlap), .x(x), .x_valid(x_valid),
    .busy(busy2), .done(done2), .match(match2), .count(count2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: the job is the list of bits consumed so far.
  bit          q[$];
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_len = 0;
  bit [3:0]    m_pat = '0;
  bit          m_ovl = 1'b0;
  int          m_floor = 0;
  int          m_raw = 0;
  logic [31:0] m_mask = '0;
  logic [31:0] dut_mask = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit exp_match();
    bit [3:0] w;
    if (!m_busy || !x_valid) return 1'b0;
    if (q.size() + 1 - m_floor < 4) return 1'b0;
    w = {q[q.size()-3], q[q.size()-2], q[q.size()-1], x};
    return w == m_pat;
  endfunction

  initial begin
    bit em;
    forever begin
      @(negedge clk);
      em = exp_match();
      if (chk_en) begin
        chk("match",  int'(match),  int'(em));
        chk("match2", int'(match2), int'(em));
        chk("busy",   int'(busy),   int'(m_busy));
        chk("done",   int'(done),   int'(m_done));
        chk("busy2",  int'(busy2),  int'(m_busy));
        chk("done2",  int'(done2),  int'(m_done));
        chk("count",  int'(count),  sat(m_raw, 255));
        chk("count2", int'(count2), sat(m_raw, 3));
        if (match) dut_mask[q.size()+1] = 1'b1;
      end
      if (reset) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_raw  = 0;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (m_busy) begin
        if (x_valid) begin
          if (em) begin
            m_raw++;
            m_mask[q.size()+1] = 1'b1;
            if (!m_ovl) m_floor = q.size() + 1;
          end
          q.push_back(x);
          if (q.size() == m_len) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (start) begin
        m_pat    = pattern;
        m_len    = int'(len);
        m_ovl    = overlap;
        q.delete();
        m_floor  = 0;
        m_raw    = 0;
        m_mask   = '0;
        dut_mask = '0;
        if (len == 0) m_done = 1'b1;
        else          m_busy = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream bits are written first-bit-leftmost: bit i is s[ln-1-i].
  task automatic run_job(input logic [3:0] pat, input int ln, input bit ovl,
                         input logic [15:0] s, input int gap_at, input int mid_start,
                         input int abort_at, input logic [31:0] exp_mask,
                         input int exp_cnt, input int exp_cnt2);
    int waited;
    pattern = pat;
    len     = 8'(ln);
    overlap = ovl;
    start   = 1'b1;
    step();
    start   = 1'b0;
    pattern = ~pat;
    len     = 8'd3;
    overlap = ~ovl;
    for (int i = 0; i < ln; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          x_valid = 1'b0;
          x = ~x;
          step();
          chk("gap_busy", int'(busy), 1);
        end
      end
      x_valid = 1'b1;
      x = s[ln-1-i];
      start = (i == mid_start);
      if (i == mid_start) begin
        pattern = 4'b0000;
        len = 8'd0;
      end
      if (i == abort_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        x_valid = 1'b0;
        chk("abort_busy",   int'(busy),   0);
        chk("abort_done",   int'(done),   0);
        chk("abort_count",  int'(count),  0);
        chk("abort_count2", int'(count2), 0);
        step();
        return;
      end
      step();
      start = 1'b0;
    end
    x_valid = 1'b0;
    waited = 0;
    while (!done && waited < 4) begin
      step();
      waited++;
    end
    chk("done_pulse",  int'(done),   1);
    chk("done_wait",   waited,       0);
    chk("job_count",   int'(count),  exp_cnt);
    chk("job_count2",  int'(count2), exp_cnt2);
    chk("job_mask",    int'(dut_mask), int'(exp_mask));
    chk("model_mask",  int'(m_mask),   int'(exp_mask));
    chk("model_count", m_raw,          exp_cnt);
    step();
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_count_hold", int'(count), exp_cnt);
  endtask

  initial begin
    reset = 1'b1;
    x = 1'(($urandom & 32'h1));
    step();
    chk_en = 1'b1;
    x = 1'(($urandom & 32'h1));
    step();
    chk("rst_busy",  int'(busy),  0);
    chk("rst_done",  int'(done),  0);
    chk("rst_match", int'(match), 0);
    chk("rst_count", int'(count), 0);
    reset = 1'b0;
    x = 1'b0;
    step();

    run_job(4'b1101, 8, 1'b1, 16'b11011010, -1, -1, -1, 32'h090, 2, 2);
    run_job(4'b1101, 8, 1'b0, 16'b11011010, -1, -1, -1, 32'h010, 1, 1);
    run_job(4'b0101, 8, 1'b1, 16'b01010101, -1, -1, -1, 32'h150, 3, 3);
    run_job(4'b0101, 8, 1'b0, 16'b01010101, -1, -1, -1, 32'h110, 2, 2);
    run_job(4'b1101, 8, 1'b1, 16'b11011010,  2, -1, -1, 32'h090, 2, 2);
    run_job(4'b1011, 0, 1'b1, 16'b0,        -1, -1, -1, 32'h000, 0, 0);
    run_job(4'b1101, 8, 1'b1, 16'b11011010, -1,  3, -1, 32'h090, 2, 2);
    run_job(4'b1111, 10, 1'b1, 16'h03FF,    -1, -1, -1, 32'h7F0, 7, 3);
    run_job(4'b1111, 10, 1'b1, 16'h03FF,    -1, -1,  4, 32'h000, 0, 0);
    run_job(4'b0110, 6, 1'b0, 16'b011011,   -1, -1, -1, 32'h010, 1, 1);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual running required finished");
    $fatal(1);
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable serial pattern-detector controller that owns and sequences one 4-bit Mealy sequence detector. It accepts a detection job (pattern, frame length, overlap mode) through a start/busy/done handshake and feeds the serial stream `x` through the detector for exactly `len` valid bits. It raises a Mealy `match` output and counts matches. It sits between the serial bit source and any consumer of match events or totals, replacing the fixed-pattern detectors.

## Interface
- `PW`, 4: pattern width in bits; fixed at 4 for this revision.
- `LW`, 8: width of the frame-length input and of the bit counter.
- `CW`, 8: width of the match counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous and active-high, sampled on the rising edge of `clk`.
- `start`  in  1  job request; accepted only in IDLE.
- `pattern`  in  PW  target pattern; MSB is the oldest bit. Latched on accept.
- `len`  in  LW  number of valid bits in the frame. Latched on accept.
- `overlap`  in  1  1 = overlapping matches allowed. Latched on accept.
- `x`  in  1  serial data bit.
- `x_valid`  in  1  `x` is consumed this cycle when high while busy.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `match`  out  1  Mealy output, combinational from `x`/`x_valid` and state.
- `count`  out  CW  matches in the current or last job.

## Operation
- FSM states: IDLE, RUN, DONE. Reset and power-up state is IDLE.
- IDLE with `start`=1:
  - Latch `pattern`, `len`, `overlap`.
  - Clear history, fill, bit counter and `count`.
  - Next state is RUN, or DONE directly if `len`==0.
- RUN, cycle with `x_valid`=1: the bit is consumed.
  - `hist` (PW-1 bits) shifts in `x`.
  - Bit counter increments.
  - `fill` increments, saturating at PW-1.
- RUN, cycle with `x_valid`=0: no state change. `match` is 0.
- `match` = RUN & `x_valid` & (`fill`==PW-1) & ({`hist`,`x`}==latched pattern).
- On `match`:
  - `count` increments, saturating at 2^CW-1.
  - If `overlap`=0, `fill` resets to 0, so the next match needs PW fresh bits.
  - If `overlap`=1, `fill` is unaffected.
- RUN to DONE on the edge that consumes bit number `len`. A match on the last bit is counted.
- DONE always goes to IDLE on the next edge.
- `start` in RUN or DONE is ignored. It is not queued.
- `count` holds its value in DONE and IDLE until the next accepted start.
- Reset asserted at any time, including mid-job: on that edge the FSM enters IDLE and clears `busy`, `done` and `count`. `match` is 0 while in IDLE.

## Timing
- Start accepted at edge k: `busy`=1 from the cycle after edge k. The first consumable bit is in that cycle.
- `match` is valid in the same cycle as its bit. `count` reflects the match after the next edge.
- Last bit consumed at edge e:
  - `busy`=0 and `done`=1 for the cycle after edge e.
  - IDLE the cycle after that. The earliest new start is accepted at the edge ending that IDLE cycle.
- `len`=0: `done` pulses in the cycle right after the accept edge, with `count`=0.
- Minimum job length is `len`+2 cycles from accept to IDLE with `x_valid` held high.
- Outputs after reset: `busy`=0, `done`=0, `match`=0, `count`=0.

## Test plan
- Reset held 2 cycles with random `x`, `start`=0 -> `busy`=0, `done`=0, `match`=0, `count`=0.
- `pattern`=1101, `overlap`=1, `len`=8, stream 1,1,0,1,1,0,1,0 with `x_valid`=1 -> `match` high on bits 4 and 7, `done` pulse, `count`=2.
  - Same stream with `overlap`=0 -> match on bit 4 only, `count`=1.
- `pattern`=0101, `len`=8, stream 01010101 -> `overlap`=1: matches on bits 4, 6 and 8, `count`=3. `overlap`=0: bits 4 and 8, `count`=2. A match on the last bit is still counted.
- `x_valid` gaps: same 1101 job with `x_valid`=0 for 3 cycles between bits 2 and 3 -> identical match positions by bit index, `count`=2.
  - `busy` stays high until bit 8.
  - Toggling `x` during the gaps has no effect.
- `len`=0 -> `done` pulses one cycle after accept, `count`=0.
  - `start` pulsed mid-RUN on a `len`=8 job is ignored: the job completes normally.
- `CW`=2, `pattern`=1111, `overlap`=1, `len`=10, all-ones stream -> 7 raw matches, `count` saturates at 3.
  - Reset asserted at bit 5 of a new job -> IDLE and `count`=0 on that edge.
